// File: rtl/can_bit_timing.sv
// can_bit_timing: CAN bit timing with prescaler, SYNC/TSEG1/TSEG2 segments, hard sync and SJW resync
module can_bit_timing #(
  parameter int BRP_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [BRP_W-1:0] brp,
  input  logic [3:0]       tseg1,
  input  logic [2:0]       tseg2,
  input  logic [1:0]       sjw,
  input  logic             hard_sync_en,
  input  logic             rx,
  output logic             tq_tick,
  output logic             bit_start,
  output logic             sample_pulse,
  output logic             sampled_bit,
  output logic [1:0]       seg_state
);
  typedef enum logic [1:0] {IDLE = 2'b00, SYNC = 2'b01, TSEG1 = 2'b10, TSEG2 = 2'b11} seg_t;
  seg_t state;
  logic rx_m, rx_s, rx_d;
  logic [BRP_W-1:0] cnt, brp_l;
  logic [3:0] tseg1_l;
  logic [2:0] tseg2_l, ext, sjw1, late_ext, ext_eff;
  logic [1:0] sjw_l;
  logic [4:0] idx, idx1, sjw1_w, remain, idx_eff, seg_last;
  logic resync_done, sync_ok, hard, late, early, early_end, shorten, seg_end, load;
  assign seg_state = state;
  always_comb begin
    sync_ok   = rx_d && !rx_s && sampled_bit && !resync_done;
    hard      = sync_ok && hard_sync_en && state != IDLE;
    late      = sync_ok && !hard_sync_en && state == TSEG1;
    early     = sync_ok && !hard_sync_en && state == TSEG2;
    sjw1      = {1'b0, sjw_l} + 3'd1;
    sjw1_w    = {2'b0, sjw1};
    idx1      = idx + 5'd1;
    late_ext  = (idx1 < sjw1_w) ? idx1[2:0] : sjw1;
    ext_eff   = late ? late_ext : ext;
    remain    = {2'b0, tseg2_l} + 5'd1 - idx;
    early_end = early && remain <= sjw1_w;
    shorten   = early && !early_end;
    idx_eff   = shorten ? idx + sjw1_w : idx;
    seg_last  = state == TSEG1 ? {1'b0, tseg1_l} + {2'b0, ext_eff} :
                state == TSEG2 ? {2'b0, tseg2_l} : 5'd0;
    tq_tick   = enable && state != IDLE && cnt == brp_l;
    seg_end   = tq_tick && idx_eff == seg_last;
    load      = enable && (state == IDLE || hard || early_end || seg_end);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) {rx_m, rx_s, rx_d} <= 3'b111;
    else      {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
  // timing parameters only change at segment boundaries
  always_ff @(posedge clk or negedge rst)
    if (!rst) {brp_l, tseg1_l, tseg2_l, sjw_l} <= '0;
    else if (load) {brp_l, tseg1_l, tseg2_l, sjw_l} <= {brp, tseg1, tseg2, sjw};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      ext          <= '0;
      resync_done  <= 1'b0;
      bit_start    <= 1'b0;
      sample_pulse <= 1'b0;
      sampled_bit  <= 1'b1;
    end else if (!enable) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      ext          <= '0;
      resync_done  <= 1'b0;
      bit_start    <= 1'b0;
      sample_pulse <= 1'b0;
    end else begin
      bit_start    <= 1'b0;
      sample_pulse <= 1'b0;
      if (state == IDLE) begin
        state     <= SYNC;
        bit_start <= 1'b1;
        cnt       <= '0;
        idx       <= '0;
      end else if (hard || early_end) begin
        state       <= TSEG1;
        cnt         <= '0;
        idx         <= '0;
        ext         <= '0;
        resync_done <= 1'b1;
      end else begin
        cnt <= tq_tick ? '0 : cnt + 1'b1;
        if (late) ext <= late_ext;
        if (late || shorten) resync_done <= 1'b1;
        if (seg_end) begin
          idx <= '0;
          if (state == SYNC) state <= TSEG1;
          else if (state == TSEG1) begin
            state        <= TSEG2;
            ext          <= '0;
            sampled_bit  <= rx_s;
            sample_pulse <= 1'b1;
            resync_done  <= 1'b0;
          end else begin
            state     <= SYNC;
            bit_start <= 1'b1;
          end
        end else idx <= tq_tick ? idx_eff + 5'd1 : idx_eff;
      end
    end
endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing: directed checks of CAN bit timing, resync, hard sync and reset
module tb_can_bit_timing;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, hard_sync_en = 1'b0, rx = 1'b1;
  logic [5:0] brp = '0;
  logic [3:0] tseg1 = '0;
  logic [2:0] tseg2 = '0;
  logic [1:0] sjw = '0;
  logic tq_tick, bit_start, sample_pulse, sampled_bit;
  logic [1:0] seg_state;
  int cyc = 0, n_chk = 0, n_pass = 0;
  can_bit_timing #(.BRP_W(6)) dut (
    .clk(clk), .rst(rst), .enable(enable), .brp(brp), .tseg1(tseg1), .tseg2(tseg2),
    .sjw(sjw), .hard_sync_en(hard_sync_en), .rx(rx), .tq_tick(tq_tick),
    .bit_start(bit_start), .sample_pulse(sample_pulse), .sampled_bit(sampled_bit),
    .seg_state(seg_state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic wait_for(input bit sp, output int c);
    c = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sp ? sample_pulse : bit_start) begin
        c = cyc;
        return;
      end
    end
    check(sp ? "sp_timeout" : "bs_timeout", 0, 1);
  endtask
  // called on the bit_start clk; falling edge lands in TSEG2 tq index 1 (2 tq left)
  task automatic sync_case(input string tag);
    int t, s, n_bs;
    n_bs = 0;
    repeat (14) @(negedge clk);
    rx = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bit_start) n_bs++;
    end
    check({tag, "_state"}, int'(seg_state), 2);
    check({tag, "_no_bs"}, n_bs, 0);
    t = cyc;
    wait_for(1'b1, s);
    check({tag, "_sp_lat"}, s - t, 12);
    check({tag, "_sampled"}, int'(sampled_bit), 0);
    rx = 1'b1;
  endtask
  initial begin
    int c, c0, c1, c2, s, nt, found;
    brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_state", int'(seg_state), 0);
    check("rst_tq", int'(tq_tick), 0);
    check("rst_bs", int'(bit_start), 0);
    check("rst_sp", int'(sample_pulse), 0);
    check("rst_sampled", int'(sampled_bit), 1);
    rst = 1'b1; enable = 1'b1;
    wait_for(1'b0, c0);
    check("bs_state", int'(seg_state), 1);
    wait_for(1'b1, s);
    check("sp_lat", s - c0, 14);
    check("sampled_1", int'(sampled_bit), 1);
    wait_for(1'b0, c);
    check("period", c - c0, 20);
    nt = 0;
    repeat (20) begin
      @(negedge clk);
      nt += int'(tq_tick);
    end
    check("tq_ticks", nt, 10);
    check("bs_after_20", int'(bit_start), 1);
    c = cyc;
    repeat (2) @(negedge clk);
    rx = 1'b0;
    wait_for(1'b0, c1);
    rx = 1'b1;
    check("ext_period", c1 - c, 22);
    check("sampled_0", int'(sampled_bit), 0);
    sjw = 2'd1;
    wait_for(1'b0, c2);
    check("period_after_ext", c2 - c1, 20);
    wait_for(1'b0, c);
    sync_case("early");
    hard_sync_en = 1'b1; sjw = 2'd0;
    wait_for(1'b0, c);
    wait_for(1'b0, c);
    sync_case("hard");
    hard_sync_en = 1'b0;
    wait_for(1'b0, c);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_state", int'(seg_state), 0);
    check("arst_tq", int'(tq_tick), 0);
    check("arst_bs", int'(bit_start), 0);
    check("arst_sp", int'(sample_pulse), 0);
    check("arst_sampled", int'(sampled_bit), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    found = 0;
    repeat (2) begin
      @(negedge clk);
      if (bit_start) found = 1;
    end
    check("bs_after_rst", found, 1);
    wait_for(1'b0, c);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_state", int'(seg_state), 0);
    check("dis_bs", int'(bit_start), 0);
    check("dis_tq", int'(tq_tick), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/can_bit_timing.md
CAN_BIT_TIMING -- requirements
Module: can_bit_timing

Interface
REQ-001 Parameter BRP_W, default 6: width of the baud-rate prescaler field.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, release is synchronous to clk.
REQ-004 enable  input  1  1 = bit timing running; 0 = return to IDLE on the next clk.
REQ-005 brp  input  BRP_W  time quantum (tq) length is brp+1 clk.
REQ-006 tseg1  input  4  PROP+PHASE1 length is tseg1+1 tq; legal range 1..15.
REQ-007 tseg2  input  3  PHASE2 length is tseg2+1 tq; legal range 1..7.
REQ-008 sjw  input  2  sync jump width is sjw+1 tq; sjw+1 <= tseg2+1.
REQ-009 hard_sync_en  input  1  1 = next qualifying edge causes a hard sync instead of a resync.
REQ-010 rx  input  1  raw CAN bus level (1 recessive, 0 dominant), asynchronous.
REQ-011 tq_tick  output  1  one-clk pulse on the last clk of every tq.
REQ-012 bit_start  output  1  one-clk pulse on the first clk of SYNC (transmit point).
REQ-013 sample_pulse  output  1  one-clk pulse when sampled_bit updates.
REQ-014 sampled_bit  output  1  bus value captured at the sample point.
REQ-015 seg_state  output  2  00 IDLE, 01 SYNC, 10 TSEG1, 11 TSEG2.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; rx_s is the second flop and rx_d is rx_s delayed one clk.
REQ-017 Prescaler SHALL count 0..brp and wrap to 0; tq_tick = enable && count==brp; the count is held at 0 in IDLE.
REQ-018 A qualifying edge SHALL be rx_d==1 && rx_s==0 && sampled_bit==1, and is evaluated every clk.
REQ-019 In IDLE, enable==1 SHALL move to SYNC with bit_start=1 and prescaler=0.
REQ-020 SYNC SHALL last 1 tq and then go to TSEG1; TSEG1 SHALL last tseg1+1 tq plus any extension, then go to TSEG2.
REQ-021 On the tq_tick that ends TSEG1, the block SHALL set sampled_bit<=rx_s and pulse sample_pulse on the next clk.
REQ-022 TSEG2 SHALL last tseg2+1 tq minus any shortening, then go to SYNC with bit_start=1.
REQ-023 A per-bit resync_done flag SHALL block further syncs until it is cleared at the sample point; a hard sync also sets it.
REQ-024 Hard sync (edge && hard_sync_en, in any non-IDLE state): the block SHALL go to TSEG1 with tq count 0 and prescaler 0, and SHALL NOT pulse bit_start. Hard sync takes priority over resync.
REQ-025 Edge in SYNC SHALL cause no action.
REQ-026 Late edge in TSEG1 at tq index k (0-based) and !resync_done: TSEG1 SHALL be extended by min(k+1, sjw+1) tq.
REQ-027 Early edge in TSEG2 with r tq remaining (including the current tq) and !resync_done:
  - if r <= sjw+1, the block SHALL end TSEG2 at once, go to TSEG1 with prescaler 0, and not pulse bit_start;
  - otherwise TSEG2 SHALL be shortened by sjw+1 tq.
REQ-028 Register changes (brp, tseg1, tseg2, sjw) SHALL take effect only at the next segment boundary.
REQ-029 enable=0 mid-bit SHALL go to IDLE on the next clk, clear all pulses, and hold sampled_bit.

Reset
REQ-030 While rst==0: seg_state=IDLE, prescaler=0, tq count=0, extension=0, resync_done=0, tq_tick=0, bit_start=0, sample_pulse=0, sampled_bit=1, synchronizer flops=1.
REQ-031 Reset asserted mid-bit SHALL abort immediately with no residual pulse after release.

Verification
REQ-032 brp=1, tseg1=5, tseg2=2, rx=1, enable=1 -> bit_start period 20 clk, sample_pulse 14 clk after each bit_start, tq_tick every 2 clk.
REQ-033 Same config, rx falls in TSEG1 tq index 1, sjw=0 -> that bit lasts 22 clk; the next bit returns to 20 clk.
REQ-034 Same config, sjw=1, rx falls in TSEG2 with 2 tq left -> TSEG2 ends immediately; the next sample_pulse comes 12 clk after the edge is seen.
REQ-035 hard_sync_en=1, rx falls mid-TSEG2 -> seg_state=TSEG1 on the next clk; no bit_start; sample_pulse 12 clk later.
REQ-036 rst pulled low mid-TSEG1 -> all outputs go to their reset values at once; after release with enable=1, bit_start is seen within 2 clk.
